// File: rtl/coeff_token_ctrl_pkg.sv
// Shared types and constants for the coeff_token decode controller.
// Holds the FSM encoding, ROM table selects, nC classification and code limits.
package coeff_token_ctrl_pkg;

   localparam int unsigned NC_W      = 6;
   localparam int unsigned TC_W      = 5;
   localparam int unsigned T1_W      = 2;
   localparam int unsigned SHIFT_W   = 5;
   localparam int unsigned ROM_SEL_W = 2;
   localparam int unsigned FLC_W     = 6;

   localparam int unsigned TC_INVALID  = 31;
   localparam int unsigned MAX_TC_LUMA = 16;
   localparam int unsigned MAX_TC_CDC  = 4;
   localparam int unsigned FLC_SHIFT   = 6;
   localparam logic [FLC_W-1:0] FLC_ZERO_CODE = 6'b000011;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_BITS = 3'd1,
      ST_LOOKUP    = 3'd2,
      ST_SHIFT     = 3'd3,
      ST_RESULT    = 3'd4
   } state_e;

   typedef enum logic [ROM_SEL_W-1:0] {
      ROM_SEL_NC0 = 2'd0,
      ROM_SEL_NC2 = 2'd1,
      ROM_SEL_NC4 = 2'd2,
      ROM_SEL_CDC = 2'd3
   } rom_sel_e;

   typedef enum logic [1:0] {
      CLS_ROM     = 2'd0,
      CLS_FLC     = 2'd1,
      CLS_ILLEGAL = 2'd2
   } nc_class_e;

   typedef struct packed {
      logic [TC_W-1:0]    total_coeff;
      logic [T1_W-1:0]    trailing_ones;
      logic [SHIFT_W-1:0] num_shift;
      logic               error;
   } token_t;

   // nC below -1 has no table; nC of 8 or more uses the 6-bit fixed-length code.
   function automatic nc_class_e nc_class(input logic [NC_W-1:0] nc);
      logic signed [NC_W-1:0] s;
      s = $signed(nc);
      if (s < -6'sd1)
         return CLS_ILLEGAL;
      else if (s >= 6'sd8)
         return CLS_FLC;
      else
         return CLS_ROM;
   endfunction

   function automatic rom_sel_e nc_rom_sel(input logic [NC_W-1:0] nc);
      logic signed [NC_W-1:0] s;
      s = $signed(nc);
      if (s == -6'sd1)
         return ROM_SEL_CDC;
      else if (s < 6'sd2)
         return ROM_SEL_NC0;
      else if (s < 6'sd4)
         return ROM_SEL_NC2;
      else if (s < 6'sd8)
         return ROM_SEL_NC4;
      else
         return ROM_SEL_NC0;
   endfunction

endpackage

// File: rtl/coeff_token_flc_dec.sv
// Fixed-length coeff_token decode (nC >= 8): 6-bit xxxxyy code to
// TotalCoeff/TrailingOnes, flagging codes whose trailing ones exceed the count.
module coeff_token_flc_dec
   import coeff_token_ctrl_pkg::*;
(
   input  logic [FLC_W-1:0] code_i,
   output logic [TC_W-1:0]  total_coeff_o,
   output logic [T1_W-1:0]  trailing_ones_o,
   output logic             error_o
);

   always_comb begin
      total_coeff_o   = '0;
      trailing_ones_o = '0;
      error_o         = 1'b0;
      if (code_i != FLC_ZERO_CODE) begin
         total_coeff_o   = TC_W'(code_i[FLC_W-1:2]) + TC_W'(1);
         trailing_ones_o = code_i[1:0];
         error_o         = TC_W'(code_i[1:0]) > total_coeff_o;
      end
   end

endmodule

// File: rtl/coeff_token_ctrl.sv
// coeff_token decode controller: classifies nC, looks up the token from an
// external ROM or the FLC decoder, consumes its bits and presents the result.
module coeff_token_ctrl
   import coeff_token_ctrl_pkg::*;
#(
   parameter int unsigned WIN_W = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [NC_W-1:0]    nc_i,
   output logic               busy_o,
   input  logic [WIN_W-1:0]   bit_window_i,
   input  logic               bit_valid_i,
   output logic               shift_valid_o,
   output logic [SHIFT_W-1:0] shift_amt_o,
   input  logic               shift_ready_i,
   output logic [1:0]         rom_sel_o,
   output logic [WIN_W-1:0]   rom_address_o,
   input  logic [TC_W-1:0]    rom_total_coeff_i,
   input  logic [T1_W-1:0]    rom_trailing_ones_i,
   input  logic [SHIFT_W-1:0] rom_num_shift_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [TC_W-1:0]    out_total_coeff_o,
   output logic [T1_W-1:0]    out_trailing_ones_o,
   output logic               out_error_o,
   output logic [CNT_W-1:0]   token_count_o
);

   state_e             state_q, state_d;
   logic [NC_W-1:0]    nc_q, nc_d;
   rom_sel_e           rom_sel_q, rom_sel_d;
   logic [SHIFT_W-1:0] shift_amt_q, shift_amt_d;
   logic [TC_W-1:0]    tc_q, tc_d;
   logic [T1_W-1:0]    t1_q, t1_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               shift_valid_q, shift_valid_d;
   logic               out_valid_q, out_valid_d;

   logic [TC_W-1:0]    flc_tc;
   logic [T1_W-1:0]    flc_t1;
   logic               flc_err;
   token_t             lk;

   coeff_token_flc_dec u_flc_dec (
      .code_i          (bit_window_i[WIN_W-1 -: FLC_W]),
      .total_coeff_o   (flc_tc),
      .trailing_ones_o (flc_t1),
      .error_o         (flc_err)
   );

   // Token candidate for the LOOKUP cycle, from either the ROM or the FLC decoder.
   always_comb begin
      lk = '0;
      if (nc_class(nc_q) == CLS_FLC) begin
         lk.total_coeff   = flc_tc;
         lk.trailing_ones = flc_t1;
         lk.num_shift     = SHIFT_W'(FLC_SHIFT);
         lk.error         = flc_err;
      end else begin
         lk.total_coeff   = rom_total_coeff_i;
         lk.trailing_ones = rom_trailing_ones_i;
         lk.num_shift     = rom_num_shift_i;
         lk.error         = (rom_total_coeff_i == TC_W'(TC_INVALID)) ||
                            (rom_num_shift_i == '0) ||
                            ((rom_sel_q == ROM_SEL_CDC) ? (rom_total_coeff_i > TC_W'(MAX_TC_CDC))
                                                        : (rom_total_coeff_i > TC_W'(MAX_TC_LUMA)));
      end
   end

   always_comb begin
      state_d     = state_q;
      nc_d        = nc_q;
      rom_sel_d   = rom_sel_q;
      shift_amt_d = shift_amt_q;
      tc_d        = tc_q;
      t1_d        = t1_q;
      err_d       = err_q;
      cnt_d       = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               nc_d      = nc_i;
               rom_sel_d = nc_rom_sel(nc_i);
               if (nc_class(nc_i) == CLS_ILLEGAL) begin
                  tc_d    = '0;
                  t1_d    = '0;
                  err_d   = 1'b1;
                  state_d = ST_RESULT;
               end else begin
                  state_d = ST_WAIT_BITS;
               end
            end
         end
         ST_WAIT_BITS: begin
            if (bit_valid_i) state_d = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            if (lk.error) begin
               tc_d    = '0;
               t1_d    = '0;
               err_d   = 1'b1;
               state_d = ST_RESULT;
            end else begin
               tc_d        = lk.total_coeff;
               t1_d        = lk.trailing_ones;
               err_d       = 1'b0;
               shift_amt_d = lk.num_shift;
               state_d     = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (shift_ready_i) state_d = ST_RESULT;
         end
         ST_RESULT: begin
            if (out_ready_i) begin
               state_d = ST_IDLE;
               if (!err_q && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d        = (state_d != ST_IDLE);
      shift_valid_d = (state_d == ST_SHIFT);
      out_valid_d   = (state_d == ST_RESULT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         nc_q          <= '0;
         rom_sel_q     <= ROM_SEL_NC0;
         shift_amt_q   <= '0;
         tc_q          <= '0;
         t1_q          <= '0;
         err_q         <= 1'b0;
         cnt_q         <= '0;
         busy_q        <= 1'b0;
         shift_valid_q <= 1'b0;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         nc_q          <= nc_d;
         rom_sel_q     <= rom_sel_d;
         shift_amt_q   <= shift_amt_d;
         tc_q          <= tc_d;
         t1_q          <= t1_d;
         err_q         <= err_d;
         cnt_q         <= cnt_d;
         busy_q        <= busy_d;
         shift_valid_q <= shift_valid_d;
         out_valid_q   <= out_valid_d;
      end
   end

   // The ROM address follows the live window so the ROM result is ready in LOOKUP.
   assign rom_address_o       = bit_window_i;
   assign rom_sel_o           = rom_sel_q;
   assign busy_o              = busy_q;
   assign shift_valid_o       = shift_valid_q;
   assign shift_amt_o         = shift_amt_q;
   assign out_valid_o         = out_valid_q;
   assign out_total_coeff_o   = tc_q;
   assign out_trailing_ones_o = t1_q;
   assign out_error_o         = err_q;
   assign token_count_o       = cnt_q;

endmodule

// File: tb/tb_coeff_token_ctrl.sv
// Self-checking bench for coeff_token_ctrl: directed cases plus randomized
// tokens and backpressure, checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_coeff_token_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [5:0]  nc_i;
   logic        busy_o;
   logic [15:0] bit_window_i;
   logic        bit_valid_i;
   logic        shift_valid_o;
   logic [4:0]  shift_amt_o;
   logic        shift_ready_i;
   logic [1:0]  rom_sel_o;
   logic [15:0] rom_address_o;
   logic [4:0]  rom_tc;
   logic [1:0]  rom_t1;
   logic [4:0]  rom_sh;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [4:0]  out_total_coeff_o;
   logic [1:0]  out_trailing_ones_o;
   logic        out_error_o;
   logic [15:0] token_count_o;

   always #5 clk = ~clk;

   coeff_token_ctrl #(.WIN_W(16), .CNT_W(16)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .start_i             (start_i),
      .nc_i                (nc_i),
      .busy_o              (busy_o),
      .bit_window_i        (bit_window_i),
      .bit_valid_i         (bit_valid_i),
      .shift_valid_o       (shift_valid_o),
      .shift_amt_o         (shift_amt_o),
      .shift_ready_i       (shift_ready_i),
      .rom_sel_o           (rom_sel_o),
      .rom_address_o       (rom_address_o),
      .rom_total_coeff_i   (rom_tc),
      .rom_trailing_ones_i (rom_t1),
      .rom_num_shift_i     (rom_sh),
      .out_valid_o         (out_valid_o),
      .out_ready_i         (out_ready_i),
      .out_total_coeff_o   (out_total_coeff_o),
      .out_trailing_ones_o (out_trailing_ones_o),
      .out_error_o         (out_error_o),
      .token_count_o       (token_count_o)
   );

   // External lookup ROM stand-in: a few real table-0 codes plus a hashed filler.
   function automatic logic [11:0] rom_fn(input logic [1:0] sel, input logic [15:0] w);
      logic [4:0] tc;
      logic [1:0] t1;
      logic [4:0] sh;
      if (w == 16'h0000) begin
         tc = 5'd31; t1 = 2'd0; sh = 5'd0;
      end else if (sel == 2'd0 && w[15]) begin
         tc = 5'd0; t1 = 2'd0; sh = 5'd1;
      end else if (sel == 2'd0 && w[15:10] == 6'b000101) begin
         tc = 5'd1; t1 = 2'd0; sh = 5'd6;
      end else begin
         tc = (w[7:5] == 3'd0) ? 5'd31 : 5'(32'(w[4:0]) % 32'd18);
         t1 = w[9:8];
         sh = w[14:10];
      end
      return {tc, t1, sh};
   endfunction

   always_comb {rom_tc, rom_t1, rom_sh} = rom_fn(rom_sel_o, rom_address_o);

   typedef struct {
      bit illegal;
      bit flc;
      int sel;
      int tc;
      int t1;
      int amt;
      bit err;
   } exp_t;

   // Expected token for a given nC and window, straight from the decode rules.
   function automatic exp_t model(input int nc, input logic [15:0] w);
      exp_t e;
      logic [11:0] r;
      logic [5:0]  c;
      e = '{default: 0};
      if (nc < -1) begin
         e.illegal = 1'b1;
         e.err     = 1'b1;
         return e;
      end
      if (nc == -1)     e.sel = 3;
      else if (nc < 2)  e.sel = 0;
      else if (nc < 4)  e.sel = 1;
      else if (nc < 8)  e.sel = 2;
      else              e.flc = 1'b1;
      if (e.flc) begin
         c     = w[15:10];
         e.amt = 6;
         if (c == 6'd3) begin
            e.tc = 0; e.t1 = 0;
         end else begin
            e.tc = int'(c[5:2]) + 1;
            e.t1 = int'(c[1:0]);
         end
         e.err = (e.t1 > e.tc);
      end else begin
         r     = rom_fn(2'(e.sel), w);
         e.tc  = int'(r[11:7]);
         e.t1  = int'(r[6:5]);
         e.amt = int'(r[4:0]);
         e.err = (e.tc == 31) || (e.amt == 0) || ((e.sel == 3) ? (e.tc > 4) : (e.tc > 16));
      end
      if (e.err) begin
         e.tc = 0; e.t1 = 0;
      end
      return e;
   endfunction

   int   n_checks = 0;
   int   n_errors = 0;
   int   phase;          // 0 idle, 1 waiting for bits, 2 lookup, 3 shift, 4 result
   int   exp_count;
   exp_t cur;
   int   last_tc, last_t1, last_err, last_amt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("busy", 32'(busy_o), 32'(phase != 0));
      chk("shift_valid", 32'(shift_valid_o), 32'(phase == 3));
      chk("out_valid", 32'(out_valid_o), 32'(phase == 4));
      chk("token_count", 32'(token_count_o), 32'(exp_count));
      if ((phase == 1 || phase == 2) && !cur.flc) begin
         chk("rom_sel", 32'(rom_sel_o), 32'(cur.sel));
         chk("rom_address", 32'(rom_address_o), 32'(bit_window_i));
      end
      if (phase == 3) begin
         chk("shift_amt", 32'(shift_amt_o), 32'(cur.amt));
         last_amt = int'(shift_amt_o);
      end
      if (phase == 4) begin
         chk("out_total_coeff", 32'(out_total_coeff_o), 32'(cur.tc));
         chk("out_trailing_ones", 32'(out_trailing_ones_o), 32'(cur.t1));
         chk("out_error", 32'(out_error_o), 32'(cur.err));
         last_tc  = int'(out_total_coeff_o);
         last_t1  = int'(out_trailing_ones_o);
         last_err = int'(out_error_o);
      end
   end

   // Random noise on inputs the current state must ignore.
   task automatic junk();
      start_i       = 1'($urandom);
      nc_i          = 6'($urandom);
      shift_ready_i = 1'($urandom);
      out_ready_i   = 1'($urandom);
   endtask

   task automatic run_tok(input int nc, input logic [15:0] w, input int nb,
                          input int ns, input int no, input bit rst_mid);
      exp_t e;
      e   = model(nc, w);
      cur = e;
      start_i      = 1'b1;
      nc_i         = 6'(nc);
      bit_valid_i  = 1'b0;
      bit_window_i = 16'($urandom);
      @(posedge clk); #1;
      start_i = 1'b0;
      if (e.illegal) begin
         phase = 4;
      end else begin
         phase = 1;
         for (int i = 0; i < nb; i++) begin
            junk();
            bit_valid_i  = 1'b0;
            bit_window_i = 16'($urandom);
            @(posedge clk); #1;
         end
         junk();
         bit_valid_i  = 1'b1;
         bit_window_i = w;
         @(posedge clk); #1;
         phase = 2;
         junk();
         bit_valid_i = 1'($urandom);
         @(posedge clk); #1;
         phase        = e.err ? 4 : 3;
         bit_window_i = 16'($urandom);
         if (phase == 3) begin
            if (rst_mid) begin
               start_i       = 1'b0;
               shift_ready_i = 1'b0;
               @(posedge clk); #2;
               rst_n = 1'b0;
               #1;
               chk("rst_busy", 32'(busy_o), 32'd0);
               chk("rst_shift_valid", 32'(shift_valid_o), 32'd0);
               chk("rst_shift_amt", 32'(shift_amt_o), 32'd0);
               chk("rst_out_valid", 32'(out_valid_o), 32'd0);
               chk("rst_out_error", 32'(out_error_o), 32'd0);
               chk("rst_out_tc", 32'(out_total_coeff_o), 32'd0);
               chk("rst_out_t1", 32'(out_trailing_ones_o), 32'd0);
               chk("rst_token_count", 32'(token_count_o), 32'd0);
               chk("rst_rom_sel", 32'(rom_sel_o), 32'd0);
               phase     = 0;
               exp_count = 0;
               repeat (2) @(posedge clk);
               #1;
               rst_n = 1'b1;
               repeat (6) begin
                  bit_valid_i   = 1'($urandom);
                  shift_ready_i = 1'($urandom);
                  out_ready_i   = 1'($urandom);
                  bit_window_i  = 16'($urandom);
                  @(posedge clk); #1;
               end
               return;
            end
            for (int i = 0; i < ns; i++) begin
               junk();
               shift_ready_i = 1'b0;
               @(posedge clk); #1;
            end
            junk();
            shift_ready_i = 1'b1;
            @(posedge clk); #1;
            phase = 4;
         end
      end
      for (int i = 0; i < no; i++) begin
         junk();
         out_ready_i  = 1'b0;
         bit_window_i = 16'($urandom);
         @(posedge clk); #1;
      end
      junk();
      out_ready_i = 1'b1;
      @(posedge clk); #1;
      phase = 0;
      if (!e.err && exp_count != 65535) exp_count++;
      start_i     = 1'b0;
      out_ready_i = 1'b0;
   endtask

   initial begin
      int nc;
      logic [15:0] w;
      rst_n         = 1'b0;
      start_i       = 1'b0;
      nc_i          = '0;
      bit_window_i  = '0;
      bit_valid_i   = 1'b0;
      shift_ready_i = 1'b0;
      out_ready_i   = 1'b0;
      phase         = 0;
      exp_count     = 0;
      cur           = '{default: 0};
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy_o), 32'd0);
      chk("reset_out_valid", 32'(out_valid_o), 32'd0);
      chk("reset_shift_amt", 32'(shift_amt_o), 32'd0);
      chk("reset_rom_sel", 32'(rom_sel_o), 32'd0);
      chk("reset_token_count", 32'(token_count_o), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_tok(1, 16'h1400, 0, 0, 0, 1'b0);
      chk("lit_nc1_tc", 32'(last_tc), 32'd1);
      chk("lit_nc1_t1", 32'(last_t1), 32'd0);
      chk("lit_nc1_amt", 32'(last_amt), 32'd6);
      chk("lit_nc1_count", 32'(token_count_o), 32'd1);

      run_tok(0, 16'h8000, 0, 0, 0, 1'b0);
      chk("lit_nc0_tc", 32'(last_tc), 32'd0);
      chk("lit_nc0_amt", 32'(last_amt), 32'd1);

      run_tok(10, 16'h0C00, 0, 0, 0, 1'b0);
      chk("lit_flc0_tc", 32'(last_tc), 32'd0);
      chk("lit_flc0_amt", 32'(last_amt), 32'd6);

      run_tok(10, 16'h0400, 0, 0, 0, 1'b0);
      chk("lit_flc1_tc", 32'(last_tc), 32'd1);
      chk("lit_flc1_t1", 32'(last_t1), 32'd1);
      chk("lit_flc1_count", 32'(token_count_o), 32'd4);

      run_tok(0, 16'h0000, 0, 0, 0, 1'b0);
      chk("lit_romerr_err", 32'(last_err), 32'd1);
      chk("lit_romerr_count", 32'(token_count_o), 32'd4);

      run_tok(-2, 16'h1234, 0, 0, 0, 1'b0);
      chk("lit_illegal_err", 32'(last_err), 32'd1);
      chk("lit_illegal_tc", 32'(last_tc), 32'd0);

      run_tok(1, 16'h1400, 2, 3, 4, 1'b0);
      chk("lit_bp_tc", 32'(last_tc), 32'd1);
      chk("lit_bp_count", 32'(token_count_o), 32'd5);

      for (int k = 0; k < 200; k++) begin
         repeat ($urandom_range(2)) begin
            start_i       = 1'b0;
            bit_valid_i   = 1'($urandom);
            shift_ready_i = 1'($urandom);
            out_ready_i   = 1'($urandom);
            bit_window_i  = 16'($urandom);
            @(posedge clk); #1;
         end
         nc = int'($urandom_range(39)) - 8;
         w  = ($urandom_range(15) == 0) ? 16'h0000 : 16'($urandom);
         run_tok(nc, w, int'($urandom_range(3)), int'($urandom_range(3)),
                 int'($urandom_range(3)), 1'b0);
      end

      run_tok(1, 16'h1400, 0, 2, 0, 1'b1);
      run_tok(0, 16'h8000, 0, 0, 0, 1'b0);
      chk("lit_post_reset_count", 32'(token_count_o), 32'd1);

      @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
